// File: rtl/tlb_op_unit_if.sv
// rtl/tlb_op_unit_if.sv - op request, CP0 access and TLB search/write/read port bundle for tlb_op_unit
interface tlb_op_unit_if #(
   parameter int TLBNUM = 16
);
   localparam int IW = $clog2(TLBNUM);

   logic          op_valid;
   logic [1:0]    op_code;
   logic          op_ready;
   logic          op_done;

   logic          cp0_we;
   logic [4:0]    cp0_addr;
   logic [31:0]   cp0_wdata;
   logic [31:0]   cp0_rdata;

   logic [18:0]   s_vpn2;
   logic          s_odd_page;
   logic [7:0]    s_asid;
   logic          s_found;
   logic [IW-1:0] s_index;

   logic          we;
   logic [IW-1:0] w_index;
   logic [18:0]   w_vpn2;
   logic [7:0]    w_asid;
   logic          w_g;
   logic [19:0]   w_pfn0;
   logic [2:0]    w_c0;
   logic          w_d0;
   logic          w_v0;
   logic [19:0]   w_pfn1;
   logic [2:0]    w_c1;
   logic          w_d1;
   logic          w_v1;

   logic [IW-1:0] r_index;
   logic [18:0]   r_vpn2;
   logic [7:0]    r_asid;
   logic          r_g;
   logic [19:0]   r_pfn0;
   logic [2:0]    r_c0;
   logic          r_d0;
   logic          r_v0;
   logic [19:0]   r_pfn1;
   logic [2:0]    r_c1;
   logic          r_d1;
   logic          r_v1;

   // master: MEM-stage issuer plus tlb array; slave: the sequencer
   modport master (
      output op_valid, op_code, cp0_we, cp0_addr, cp0_wdata,
      output s_found, s_index,
      output r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
      input  op_ready, op_done, cp0_rdata, s_vpn2, s_odd_page, s_asid,
      input  we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
      input  w_pfn1, w_c1, w_d1, w_v1, r_index
   );

   modport slave (
      input  op_valid, op_code, cp0_we, cp0_addr, cp0_wdata,
      input  s_found, s_index,
      input  r_vpn2, r_asid, r_g, r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1,
      output op_ready, op_done, cp0_rdata, s_vpn2, s_odd_page, s_asid,
      output we, w_index, w_vpn2, w_asid, w_g, w_pfn0, w_c0, w_d0, w_v0,
      output w_pfn1, w_c1, w_d1, w_v1, r_index
   );
endinterface

// File: rtl/tlb_op_unit.sv
// rtl/tlb_op_unit.sv - TLBP/TLBR/TLBWI/TLBWR sequencer owning CP0 Index/Random/EntryLo0/EntryLo1/EntryHi
// Optional feature macro: TLB_RANDOM_EN (Random counter; TLBWR writes at Random)
module tlb_op_unit #(
   parameter int TLBNUM = 16
) (
   input logic          clk,
   input logic          resetn,
   tlb_op_unit_if.slave bus
);
   localparam int IW = $clog2(TLBNUM);
   localparam logic [1:0] OP_TLBP = 2'd0;
   localparam logic [1:0] OP_TLBR = 2'd1;

   typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

   state_t        state, state_nxt;
   logic [1:0]    op_q;
   logic          ready_int, done_int, we_int;
   logic          exec_tlbp, exec_tlbr;

   logic          index_p;
   logic [IW-1:0] index_idx;
   logic [18:0]   hi_vpn2;
   logic [7:0]    hi_asid;
   logic [25:0]   lo0, lo1;
   logic [IW-1:0] random_val;
   logic [31:0]   rdata;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state <= IDLE;
         op_q  <= OP_TLBP;
      end else begin
         state <= state_nxt;
         if (bus.op_valid && ready_int)
            op_q <= bus.op_code;
      end
   end

   always_comb begin
      state_nxt = state;
      ready_int = 1'b0;
      done_int  = 1'b0;
      we_int    = 1'b0;
      case (state)
         IDLE: begin
            ready_int = 1'b1;
            if (bus.op_valid)
               state_nxt = EXEC;
         end
         EXEC: begin
            we_int    = op_q[1];
            state_nxt = DONE;
         end
         DONE: begin
            done_int  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign exec_tlbp = (state == EXEC) && (op_q == OP_TLBP);
   assign exec_tlbr = (state == EXEC) && (op_q == OP_TLBR);

   // Op results are assigned after the MTC0 decode so they win a same-edge collision
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         index_p   <= 1'b0;
         index_idx <= '0;
         hi_vpn2   <= '0;
         hi_asid   <= '0;
         lo0       <= '0;
         lo1       <= '0;
      end else begin
         if (bus.cp0_we) begin
            case (bus.cp0_addr)
               5'd0: begin
                  index_p   <= bus.cp0_wdata[31];
                  index_idx <= bus.cp0_wdata[IW-1:0];
               end
               5'd2: lo0 <= bus.cp0_wdata[25:0];
               5'd3: lo1 <= bus.cp0_wdata[25:0];
               5'd10: begin
                  hi_vpn2 <= bus.cp0_wdata[31:13];
                  hi_asid <= bus.cp0_wdata[7:0];
               end
               default: ;
            endcase
         end
         if (exec_tlbp) begin
            index_p   <= ~bus.s_found;
            index_idx <= bus.s_found ? bus.s_index : index_idx;
         end
         if (exec_tlbr) begin
            hi_vpn2 <= bus.r_vpn2;
            hi_asid <= bus.r_asid;
            lo0     <= {bus.r_pfn0, bus.r_c0, bus.r_d0, bus.r_v0, bus.r_g};
            lo1     <= {bus.r_pfn1, bus.r_c1, bus.r_d1, bus.r_v1, bus.r_g};
         end
      end
   end

`ifdef TLB_RANDOM_EN
   localparam logic [1:0] OP_TLBWR = 2'd3;
   logic [IW-1:0] random_q;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn)
         random_q <= IW'(TLBNUM - 1);
      else
         random_q <= (random_q == '0) ? IW'(TLBNUM - 1) : random_q - IW'(1);
   end

   assign random_val  = random_q;
   assign bus.w_index = (op_q == OP_TLBWR) ? random_q : index_idx;
`else
   assign random_val  = '0;
   assign bus.w_index = index_idx;
`endif

   always_comb begin
      rdata = 32'd0;
      case (bus.cp0_addr)
         5'd0:    rdata = {index_p, {(31-IW){1'b0}}, index_idx};
         5'd1:    rdata = {{(32-IW){1'b0}}, random_val};
         5'd2:    rdata = {6'd0, lo0};
         5'd3:    rdata = {6'd0, lo1};
         5'd10:   rdata = {hi_vpn2, 5'd0, hi_asid};
         default: rdata = 32'd0;
      endcase
   end

   assign bus.op_ready   = ready_int;
   assign bus.op_done    = done_int;
   assign bus.cp0_rdata  = rdata;

   assign bus.s_vpn2     = hi_vpn2;
   assign bus.s_odd_page = 1'b0;
   assign bus.s_asid     = hi_asid;

   assign bus.we         = we_int;
   assign bus.w_vpn2     = hi_vpn2;
   assign bus.w_asid     = hi_asid;
   assign bus.w_g        = lo0[0] & lo1[0];
   assign bus.w_pfn0     = lo0[25:6];
   assign bus.w_c0       = lo0[5:3];
   assign bus.w_d0       = lo0[2];
   assign bus.w_v0       = lo0[1];
   assign bus.w_pfn1     = lo1[25:6];
   assign bus.w_c1       = lo1[5:3];
   assign bus.w_d1       = lo1[2];
   assign bus.w_v1       = lo1[1];

   assign bus.r_index    = index_idx;

   logic unused_wdata;
   assign unused_wdata = ^{bus.cp0_wdata[30:26], bus.cp0_wdata[12:8]};
endmodule

// File: tb/tb_tlb_op_unit.sv
// tb/tb_tlb_op_unit.sv - table-driven bench for tlb_op_unit with a behavioural 16-entry tlb array
module tb_tlb_op_unit;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   tlb_op_unit_if #(.TLBNUM(16)) bus ();
   tlb_op_unit #(.TLBNUM(16)) dut (.clk(clk), .resetn(resetn), .bus(bus));

   typedef struct packed {
      logic [18:0] vpn2; logic [7:0] asid; logic g;
      logic [19:0] pfn0; logic [2:0] c0; logic d0; logic v0;
      logic [19:0] pfn1; logic [2:0] c1; logic d1; logic v1;
   } tlbe_t;
   tlbe_t tlb_m [16];

   always @(posedge clk) begin
      if (!resetn) begin
         for (int i = 0; i < 16; i++) tlb_m[i] <= '0;
      end else if (bus.we) begin
         tlb_m[bus.w_index] <= {bus.w_vpn2, bus.w_asid, bus.w_g,
                                bus.w_pfn0, bus.w_c0, bus.w_d0, bus.w_v0,
                                bus.w_pfn1, bus.w_c1, bus.w_d1, bus.w_v1};
      end
   end

   always_comb begin
      bus.s_found = 1'b0;
      bus.s_index = 4'd0;
      for (int i = 15; i >= 0; i--) begin
         if (tlb_m[i].vpn2 == bus.s_vpn2 && (tlb_m[i].g || tlb_m[i].asid == bus.s_asid)) begin
            bus.s_found = 1'b1;
            bus.s_index = 4'(i);
         end
      end
   end

   assign bus.r_vpn2 = tlb_m[bus.r_index].vpn2;
   assign bus.r_asid = tlb_m[bus.r_index].asid;
   assign bus.r_g    = tlb_m[bus.r_index].g;
   assign bus.r_pfn0 = tlb_m[bus.r_index].pfn0;
   assign bus.r_c0   = tlb_m[bus.r_index].c0;
   assign bus.r_d0   = tlb_m[bus.r_index].d0;
   assign bus.r_v0   = tlb_m[bus.r_index].v0;
   assign bus.r_pfn1 = tlb_m[bus.r_index].pfn1;
   assign bus.r_c1   = tlb_m[bus.r_index].c1;
   assign bus.r_d1   = tlb_m[bus.r_index].d1;
   assign bus.r_v1   = tlb_m[bus.r_index].v1;

   // Reference Random: TLBNUM-1 at reset, minus one per clock since release
   int rel_cyc = 0;
   always @(posedge clk) begin
      if (!resetn) rel_cyc <= 0;
      else         rel_cyc <= rel_cyc + 1;
   end

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   localparam int K_WR = 0, K_RD = 1, K_OP = 2, K_OPW = 3;
   typedef struct {
      int kind; logic [4:0] addr; logic [31:0] data; logic [1:0] op;
      logic [3:0] e_widx; logic [18:0] e_vpn2; logic [7:0] e_asid;
      logic [19:0] e_pfn0; logic [19:0] e_pfn1; logic e_g;
   } vec_t;
   vec_t vq[$];

   task automatic add(input int k, input logic [4:0] a, input logic [31:0] d, input logic [1:0] op);
      vec_t v;
      v = '{k, a, d, op, 4'd0, 19'd0, 8'd0, 20'd0, 20'd0, 1'b0};
      vq.push_back(v);
   endtask

   task automatic add_opw(input logic [3:0] widx, input logic [18:0] vpn2, input logic [7:0] asid,
                          input logic [19:0] pfn0, input logic [19:0] pfn1, input logic g);
      vec_t v;
      v = '{K_OPW, 5'd0, 32'd0, 2'd2, widx, vpn2, asid, pfn0, pfn1, g};
      vq.push_back(v);
   endtask

   int we_cnt, done_cyc;
   logic [3:0] cap_widx, cap_exp_rand;
   logic [18:0] cap_vpn2;
   logic [7:0] cap_asid;
   logic [19:0] cap_pfn0, cap_pfn1;
   logic cap_g;
   logic [31:0] cap_exec_rd, cap_done_rd;

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      bus.cp0_we = 1'b1; bus.cp0_addr = a; bus.cp0_wdata = d;
      @(negedge clk);
      bus.cp0_we = 1'b0;
   endtask

   task automatic rd_chk(input string nm, input logic [4:0] a, input logic [31:0] exp);
      bus.cp0_addr = a;
      #1;
      chk(nm, bus.cp0_rdata, exp);
   endtask

   // Issues one op; optional MTC0 lands in the EXEC cycle so it collides with the op result
   task automatic run_op(input logic [1:0] op, input bit side, input logic [4:0] saddr, input logic [31:0] sdata);
      @(negedge clk);
      chk("op_ready_idle", {31'd0, bus.op_ready}, 32'd1);
      bus.op_valid = 1'b1; bus.op_code = op;
      bus.cp0_addr = side ? saddr : 5'd1;
      @(negedge clk);
      bus.op_valid = 1'b0;
      we_cnt = 0; done_cyc = 0;
      for (int c = 1; c <= 5; c++) begin
         if (bus.we) begin
            we_cnt++;
            cap_widx = bus.w_index; cap_vpn2 = bus.w_vpn2; cap_asid = bus.w_asid;
            cap_pfn0 = bus.w_pfn0;  cap_pfn1 = bus.w_pfn1; cap_g = bus.w_g;
            cap_exp_rand = 4'(15 - rel_cyc);
            cap_exec_rd = bus.cp0_rdata;
         end
         if (bus.op_done && done_cyc == 0) done_cyc = c;
         if (c == 2) cap_done_rd = bus.cp0_rdata;
         bus.cp0_we = side && (c == 1);
         bus.cp0_wdata = sdata;
         @(negedge clk);
      end
      chk("op_done_cycle", done_cyc, 2);
      chk("we_pulses", we_cnt, op[1] ? 1 : 0);
   endtask

   logic [3:0] exp_widx;
   int done_seen, wrap_seen;
   logic [31:0] prev_rd;

   initial begin
      bus.op_valid = 1'b0; bus.op_code = 2'd0;
      bus.cp0_we = 1'b0; bus.cp0_addr = 5'd0; bus.cp0_wdata = 32'd0;

      add(K_WR, 10, 32'hFFFF_FFFF, 0); add(K_RD, 10, 32'hFFFF_E0FF, 0);
      add(K_WR, 2,  32'hFFFF_FFFF, 0); add(K_RD, 2,  32'h03FF_FFFF, 0);
      add(K_WR, 0,  32'hFFFF_FFFF, 0); add(K_RD, 0,  32'h8000_000F, 0);
      add(K_WR, 10, 32'h0000_2005, 0); add(K_WR, 2, 32'h0000_0047, 0);
      add(K_WR, 3,  32'h0000_0087, 0); add(K_WR, 0, 32'h0000_0003, 0);
      add(K_RD, 10, 32'h0000_2005, 0); add(K_RD, 2, 32'h0000_0047, 0);
      add(K_RD, 3,  32'h0000_0087, 0); add(K_RD, 0, 32'h0000_0003, 0);
      add(K_RD, 5,  32'h0000_0000, 0);
      add_opw(4'd3, 19'd1, 8'h05, 20'd1, 20'd2, 1'b1);
      add(K_OP, 0, 0, 2'd0);           add(K_RD, 0, 32'h0000_0003, 0);
      add(K_WR, 10, 32'h0000_4005, 0); add(K_OP, 0, 0, 2'd0);
      add(K_RD, 0,  32'h8000_0003, 0);
      add(K_WR, 0, 32'd3, 0); add(K_WR, 10, 32'd0, 0); add(K_WR, 2, 32'd0, 0); add(K_WR, 3, 32'd0, 0);
      add(K_OP, 0, 0, 2'd1);
      add(K_RD, 10, 32'h0000_2005, 0); add(K_RD, 2, 32'h0000_0047, 0); add(K_RD, 3, 32'h0000_0087, 0);
      add(K_WR, 0, 32'd5, 0); add(K_WR, 10, 32'hFFFF_E0AB, 0);
      add(K_WR, 2, 32'h03FF_FFFE, 0); add(K_WR, 3, 32'h0000_0041, 0);
      add_opw(4'd5, 19'h7FFFF, 8'hAB, 20'hFFFFF, 20'd1, 1'b0);
      add(K_WR, 0, 32'd0, 0); add(K_OP, 0, 0, 2'd0); add(K_RD, 0, 32'h0000_0005, 0);
      add(K_WR, 10, 32'd0, 0); add(K_WR, 2, 32'd0, 0); add(K_WR, 3, 32'd0, 0);
      add(K_OP, 0, 0, 2'd1);
      add(K_RD, 10, 32'hFFFF_E0AB, 0); add(K_RD, 2, 32'h03FF_FFFE, 0); add(K_RD, 3, 32'h0000_0040, 0);

      repeat (2) @(negedge clk);
      chk("rst_op_ready", {31'd0, bus.op_ready}, 32'd1);
      chk("rst_we", {31'd0, bus.we}, 32'd0);
      chk("rst_op_done", {31'd0, bus.op_done}, 32'd0);
`ifdef TLB_RANDOM_EN
      rd_chk("rst_random", 1, 32'd15);
`else
      rd_chk("rst_random", 1, 32'd0);
`endif
      rd_chk("rst_index", 0, 32'd0);
      rd_chk("rst_entryhi", 10, 32'd0);
      rd_chk("rst_entrylo0", 2, 32'd0);
      rd_chk("rst_entrylo1", 3, 32'd0);
      @(negedge clk);
      resetn = 1'b1;

      foreach (vq[i]) begin
         case (vq[i].kind)
            K_WR: mtc0(vq[i].addr, vq[i].data);
            K_RD: rd_chk($sformatf("vec%0d_rd%0d", i, vq[i].addr), vq[i].addr, vq[i].data);
            K_OP: run_op(vq[i].op, 1'b0, 5'd0, 32'd0);
            default: begin
               run_op(vq[i].op, 1'b0, 5'd0, 32'd0);
               chk($sformatf("vec%0d_w_index", i), {28'd0, cap_widx}, {28'd0, vq[i].e_widx});
               chk($sformatf("vec%0d_w_vpn2", i),  {13'd0, cap_vpn2}, {13'd0, vq[i].e_vpn2});
               chk($sformatf("vec%0d_w_asid", i),  {24'd0, cap_asid}, {24'd0, vq[i].e_asid});
               chk($sformatf("vec%0d_w_pfn0", i),  {12'd0, cap_pfn0}, {12'd0, vq[i].e_pfn0});
               chk($sformatf("vec%0d_w_pfn1", i),  {12'd0, cap_pfn1}, {12'd0, vq[i].e_pfn1});
               chk($sformatf("vec%0d_w_g", i),     {31'd0, cap_g},    {31'd0, vq[i].e_g});
            end
         endcase
      end

      // MTC0 to Index during TLBP EXEC loses to the search result; MFC0 in the done cycle sees it
      mtc0(10, 32'h0000_2005);
      run_op(2'd0, 1'b1, 5'd0, 32'h0000_0009);
      chk("collide_done_rd", cap_done_rd, 32'h0000_0003);
      rd_chk("collide_index", 0, 32'h0000_0003);

      // TLBWR, then TLBP must find the entry at the slot it went to
      mtc0(10, 32'h0000_6007); mtc0(2, 32'h0000_0047); mtc0(3, 32'h0000_0087);
      run_op(2'd3, 1'b0, 5'd0, 32'd0);
`ifdef TLB_RANDOM_EN
      exp_widx = cap_exp_rand;
      chk("tlbwr_random_rd", cap_exec_rd, {28'd0, cap_exp_rand});
`else
      exp_widx = 4'd3;
`endif
      chk("tlbwr_w_index", {28'd0, cap_widx}, {28'd0, exp_widx});
      mtc0(0, 32'd0);
      run_op(2'd0, 1'b0, 5'd0, 32'd0);
      rd_chk("tlbwr_tlbp_index", 0, {28'd0, exp_widx});

      mtc0(1, 32'h0000_0007);
`ifdef TLB_RANDOM_EN
      bus.cp0_addr = 5'd1;
      wrap_seen = 0;
      prev_rd = 32'hFFFF_FFFF;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         chk("random_seq", bus.cp0_rdata, {28'd0, 4'(15 - rel_cyc)});
         if (prev_rd == 32'd0 && bus.cp0_rdata == 32'd15) wrap_seen++;
         prev_rd = bus.cp0_rdata;
      end
      chk("random_wrap_seen", (wrap_seen > 0) ? 32'd1 : 32'd0, 32'd1);
`else
      rd_chk("random_absent", 1, 32'd0);
`endif

      // Reset in the middle of a TLBWI EXEC cycle
      @(negedge clk);
      bus.op_valid = 1'b1; bus.op_code = 2'd2;
      @(negedge clk);
      bus.op_valid = 1'b0;
      chk("rstmid_exec_we", {31'd0, bus.we}, 32'd1);
      #1 resetn = 1'b0;
      #1;
      chk("rstmid_we_drop", {31'd0, bus.we}, 32'd0);
      chk("rstmid_ready", {31'd0, bus.op_ready}, 32'd1);
      done_seen = 0;
      repeat (3) begin
         @(negedge clk);
         if (bus.op_done) done_seen = 1;
      end
      chk("rstmid_no_done", done_seen, 0);
      resetn = 1'b1;
      @(negedge clk);
      chk("rstmid_ready_after", {31'd0, bus.op_ready}, 32'd1);
      rd_chk("rstmid_index", 0, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
